// File: rtl/divisor_pkg.sv
// Shared types and constants for the shift-subtract divider controller.
package divisor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module divisor_passo #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   r_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] t;
   logic [WIDTH:0] d_ext;
   logic           fits;
   // The partial remainder always stays below the divisor, so its MSB never feeds the shift.
   logic           r_msb_unused;

   assign r_msb_unused = r_i[WIDTH];
   assign t            = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
   assign d_ext        = {1'b0, d_i};
   assign fits         = (t >= d_ext);
   assign q_o          = {q_i[WIDTH-2:0], fits};
   assign r_o          = fits ? (t - d_ext) : t;

endmodule

// File: rtl/controle_divisor.sv
// Round-robin arbiter and sequencer for the shared shift-subtract divider.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational here
// CALC  | one restoring iteration per cycle, WIDTH cycles
// DONE  | one-cycle done pulse to the owner
module controle_divisor
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] dividendo_a,
   input  logic [WIDTH-1:0] divisor_a,
   input  logic [WIDTH-1:0] dividendo_b,
   input  logic [WIDTH-1:0] divisor_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic [WIDTH-1:0] saida,
   output logic [WIDTH-1:0] saidaResto,
   output logic             div_zero,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic [WIDTH:0]     r_q, r_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   saida_q, saida_d;
   logic [WIDTH-1:0]   resto_q, resto_d;
   logic               dz_q, dz_d;
   logic               done_a_q, done_b_q, busy_q;

   logic               req_any;
   logic               sel;
   logic [WIDTH-1:0]   op_dvd, op_dvs;
   logic [WIDTH:0]     r_n;
   logic [WIDTH-1:0]   q_n;

   assign req_any = req_a | req_b;

   // With both requesting, the side not granted last wins.
   always_comb begin
      sel = OWN_A;
      if (req_a && req_b) begin
         sel = (last_q == OWN_A) ? OWN_B : OWN_A;
      end else if (req_b) begin
         sel = OWN_B;
      end
   end

   assign op_dvd = (sel == OWN_B) ? dividendo_b : dividendo_a;
   assign op_dvs = (sel == OWN_B) ? divisor_b   : divisor_a;

   // Grant is masked by reset so every output reads 0 while rst_n is low.
   assign gnt_a = rst_n && (state_q == IDLE) && req_any && (sel == OWN_A);
   assign gnt_b = rst_n && (state_q == IDLE) && req_any && (sel == OWN_B);

   divisor_passo #(.WIDTH(WIDTH)) u_passo (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (r_n),
      .q_o (q_n)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      saida_d = saida_q;
      resto_d = resto_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               owner_d = sel;
               last_d  = sel;
               r_d     = '0;
               q_d     = op_dvd;
               d_d     = op_dvs;
               cnt_d   = CNT_W'(WIDTH - 1);
               if (op_dvs == '0) begin
                  saida_d = '1;
                  resto_d = op_dvd;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            r_d   = r_n;
            q_d   = q_n;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               saida_d = q_n;
               resto_d = r_n[WIDTH-1:0];
               dz_d    = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= OWN_A;
         last_q   <= OWN_B;
         r_q      <= '0;
         q_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         saida_q  <= '0;
         resto_q  <= '0;
         dz_q     <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         r_q      <= r_d;
         q_q      <= q_d;
         d_q      <= d_d;
         cnt_q    <= cnt_d;
         saida_q  <= saida_d;
         resto_q  <= resto_d;
         dz_q     <= dz_d;
         done_a_q <= (state_d == DONE) && (owner_d == OWN_A);
         done_b_q <= (state_d == DONE) && (owner_d == OWN_B);
         busy_q   <= (state_d != IDLE);
      end
   end

   assign done_a     = done_a_q;
   assign done_b     = done_b_q;
   assign saida      = saida_q;
   assign saidaResto = resto_q;
   assign div_zero   = dz_q;
   assign busy       = busy_q;

endmodule
